// File: rtl/fft_spectrum_server.sv
// fft_spectrum_server: captures streamed FFT frames, converts each bin to an
// approximate magnitude and saturated bar height, and serves the display's
// reads from a ping-pong bin RAM that swaps only on a vertical-sync edge.
module fft_spectrum_server #(
  parameter int       FFT_POINT = 256,
  parameter int       DATA_W    = 16,
  parameter int       DISP_H    = 720,
  parameter int       MAG_SHIFT = 4,
  parameter bit       VS_POL    = 1'b1
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic              fft_valid,
  output logic              fft_ready,
  input  logic [DATA_W-1:0] fft_re,
  input  logic [DATA_W-1:0] fft_im,
  input  logic              fft_last,
  input  logic              vs_in,
  input  logic              data_req,
  input  logic [9:0]        RAM_address,
  output logic [31:0]       fft_data,
  output logic              fft_data_valid,
  output logic [7:0]        frame_err_cnt
);

  localparam int AW     = $clog2(FFT_POINT);
  localparam int MW     = DATA_W + 1;
  localparam int STAGES = 2;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS  = ~MOST_NEG;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  // write pipeline stage payloads
  typedef struct packed {
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   word;   // {sat16(mag), height}
  } s2_t;

  // |v| with the most-negative code clamped to the largest positive value
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
    if (v == MOST_NEG)     return MAX_POS;
    else if (v[DATA_W-1])  return ~v + 1'b1;
    else                   return v;
  endfunction

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                front_q, front_d;
  logic                front_valid_q, front_valid_d;
  logic                swap_pend_q, swap_pend_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                vs1_q, vs1_d, vs2_q, vs2_d;
  logic [STAGES-1:0]   vld_pipe_q, vld_pipe_d;
  s1_t                 s1_q, s1_d;
  s2_t                 s2_q, s2_d;
  logic                req1_q, req1_d, ok1_q, ok1_d;
  logic [31:0]         fft_data_q, fft_data_d;
  logic                fft_data_valid_q, fft_data_valid_d;

  logic                rdy, acc, wr_in, vs_edge;
  logic [AW-1:0]       beat_idx;
  logic [DATA_W-1:0]   mx, mn;
  logic [MW-1:0]       mag, hs;
  logic [15:0]         raw16, h16;

  logic [31:0]         mem [0:2*FFT_POINT-1];
  logic [31:0]         rd_word_q;

  assign fft_ready      = rdy & ~rst;
  assign acc            = fft_valid & fft_ready;
  assign vs_edge        = (vs1_q == VS_POL) && (vs2_q != VS_POL);
  assign fft_data       = fft_data_q;
  assign fft_data_valid = fft_data_valid_q;
  assign frame_err_cnt  = err_cnt_q;

  // capture FSM: frame framing checks, bin indexing and bank swap on vsync
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    front_d       = front_q;
    front_valid_d = front_valid_q;
    swap_pend_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    rdy           = 1'b0;
    wr_in         = 1'b0;
    beat_idx      = idx_q;
    case (state_q)
      IDLE: begin
        rdy      = 1'b1;
        beat_idx = '0;
        if (acc) begin
          if (fft_last) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            idx_d = '0;
          end else begin
            wr_in   = 1'b1;
            idx_d   = AW'(1);
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        rdy = 1'b1;
        if (acc) begin
          if ((idx_q == AW'(FFT_POINT-1)) == fft_last) begin
            wr_in = 1'b1;
            if (fft_last) begin
              idx_d   = '0;
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            // malformed frame: drop what was captured and start over
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        // remember the edge until the last writes have landed in the back bank
        swap_pend_d = swap_pend_q | vs_edge;
        if (swap_pend_d && (vld_pipe_q == '0)) begin
          front_d       = ~front_q;
          front_valid_d = 1'b1;
          swap_pend_d   = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // magnitude pipeline and vsync edge detect
  always_comb begin
    vs1_d      = vs_in;
    vs2_d      = vs1_q;
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], wr_in};
    s1_d.idx   = beat_idx;
    s1_d.a     = abs_sat(fft_re);
    s1_d.b     = abs_sat(fft_im);
    mx         = (s1_q.a > s1_q.b) ? s1_q.a : s1_q.b;
    mn         = (s1_q.a > s1_q.b) ? s1_q.b : s1_q.a;
    mag        = MW'(mx) + MW'(mn >> 1);
    hs         = mag >> MAG_SHIFT;
    raw16      = (32'(mag) > 32'hFFFF) ? 16'hFFFF : 16'(mag);
    h16        = (32'(hs) > 32'(DISP_H-1)) ? 16'(DISP_H-1) : 16'(hs);
    s2_d.idx   = s1_q.idx;
    s2_d.word  = {raw16, h16};
  end

  // read pipeline: address check at request, RAM read, output register
  always_comb begin
    req1_d           = data_req;
    ok1_d            = front_valid_q && ({1'b0, RAM_address} < 11'(FFT_POINT));
    fft_data_valid_d = req1_q;
    fft_data_d       = fft_data_q;
    if (req1_q) fft_data_d = ok1_q ? rd_word_q : 32'd0;
  end

  // state registers
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      front_q          <= 1'b0;
      front_valid_q    <= 1'b0;
      swap_pend_q      <= 1'b0;
      err_cnt_q        <= 8'd0;
      vs1_q            <= ~VS_POL;
      vs2_q            <= ~VS_POL;
      vld_pipe_q       <= '0;
      req1_q           <= 1'b0;
      ok1_q            <= 1'b0;
      fft_data_q       <= 32'd0;
      fft_data_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      front_q          <= front_d;
      front_valid_q    <= front_valid_d;
      swap_pend_q      <= swap_pend_d;
      err_cnt_q        <= err_cnt_d;
      vs1_q            <= vs1_d;
      vs2_q            <= vs2_d;
      vld_pipe_q       <= vld_pipe_d;
      req1_q           <= req1_d;
      ok1_q            <= ok1_d;
      fft_data_q       <= fft_data_d;
      fft_data_valid_q <= fft_data_valid_d;
    end
  end

  // datapath registers carry no reset; their valid bits gate them
  always_ff @(posedge pix_clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  // ping-pong RAM: writes go to the back bank, reads from the front bank
  always_ff @(posedge pix_clk) begin
    if (vld_pipe_q[STAGES-1]) mem[{~front_q, s2_q.idx}] <= s2_q.word;
    rd_word_q <= mem[{front_q, RAM_address[AW-1:0]}];
  end

endmodule

// File: tb/tb_fft_spectrum_server.sv
// Directed bench for fft_spectrum_server: framing errors, bank swap on vsync,
// magnitude/height saturation and the two-cycle read latency.
module tb_fft_spectrum_server;

  logic        pix_clk = 1'b0;
  logic        rst, fft_valid, fft_ready, fft_last, vs_in, data_req;
  logic [15:0] fft_re, fft_im;
  logic [9:0]  RAM_address;
  logic [31:0] fft_data;
  logic        fft_data_valid;
  logic [7:0]  frame_err_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          rd_a [8];
  logic [31:0] rd_e [8];

  fft_spectrum_server dut (
    .pix_clk(pix_clk), .rst(rst), .fft_valid(fft_valid), .fft_ready(fft_ready),
    .fft_re(fft_re), .fft_im(fft_im), .fft_last(fft_last), .vs_in(vs_in),
    .data_req(data_req), .RAM_address(RAM_address), .fft_data(fft_data),
    .fft_data_valid(fft_data_valid), .frame_err_cnt(frame_err_cnt)
  );

  always #5 pix_clk = ~pix_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  function automatic logic [31:0] mkw(input int raw, input int h);
    return {16'(raw), 16'(h)};
  endfunction

  // pattern 0: re=16k, im=0 (bin 5 = worst case); 1: re=0, im=-32k (bin 7 mixed); 2: re=im=16k
  function automatic void beat(input int pat, input int k, output logic [15:0] re, output logic [15:0] im);
    case (pat)
      0: begin
        re = 16'(16*k); im = 16'd0;
        if (k == 5) begin re = 16'h8000; im = 16'h7FFF; end
      end
      1: begin
        re = 16'd0; im = 16'(-32*k);
        if (k == 7) begin re = 16'd100; im = 16'(-60); end
      end
      default: begin re = 16'(16*k); im = 16'(16*k); end
    endcase
  endfunction

  task automatic send_frame(input int pat, input int nb, input int last_at);
    for (int k = 0; k < nb; k++) begin
      int w;
      beat(pat, k, fft_re, fft_im);
      fft_valid = 1'b1;
      fft_last  = (k == last_at);
      w = 0;
      while (!fft_ready && w < 50) begin tick(); w++; end
      if (w >= 50) chk("beat_ready_timeout", {31'd0, fft_ready}, 32'd1);
      tick();
    end
    fft_valid = 1'b0;
    fft_last  = 1'b0;
  endtask

  task automatic pulse_vs();
    vs_in = 1'b1;
    repeat (3) tick();
    vs_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_rd(input int i, input int a, input logic [31:0] e);
    rd_a[i] = a;
    rd_e[i] = e;
  endtask

  // back-to-back reads; each answer must appear exactly two cycles later
  task automatic do_reads(input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i == 1) chk("rd_latency", {31'd0, fft_data_valid}, 32'd0);
      if (i >= 2) begin
        chk("rd_valid", {31'd0, fft_data_valid}, 32'd1);
        chk("rd_data", fft_data, rd_e[i-2]);
      end
      if (i < n) begin
        data_req    = 1'b1;
        RAM_address = 10'(rd_a[i]);
      end else begin
        data_req = 1'b0;
      end
      tick();
    end
    chk("rd_idle", {31'd0, fft_data_valid}, 32'd0);
    chk("rd_hold", fft_data, rd_e[n-1]);
  endtask

  initial begin
    rst = 1'b1; fft_valid = 1'b0; fft_last = 1'b0; fft_re = '0; fft_im = '0;
    vs_in = 1'b0; data_req = 1'b0; RAM_address = '0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, fft_ready}, 32'd0);
    chk("rst_valid", {31'd0, fft_data_valid}, 32'd0);
    chk("rst_data", fft_data, 32'd0);
    chk("rst_errcnt", {24'd0, frame_err_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, fft_ready}, 32'd1);

    // nothing captured yet: reads return zero
    for (int i = 0; i < 4; i++) set_rd(i, i, 32'd0);
    do_reads(4);

    // frame A, then swap it in
    send_frame(0, 256, 255);
    tick();
    chk("a_done_ready", {31'd0, fft_ready}, 32'd0);
    pulse_vs();
    chk("a_swap_ready", {31'd0, fft_ready}, 32'd1);
    set_rd(0, 10, mkw(160, 10));
    set_rd(1, 5, mkw(49150, 719));
    set_rd(2, 255, mkw(4080, 255));
    set_rd(3, 0, 32'd0);
    set_rd(4, 256, 32'd0);
    set_rd(5, 1023, 32'd0);
    do_reads(6);

    // early fft_last: error, front bank untouched
    send_frame(1, 101, 100);
    tick();
    chk("err_early_cnt", {24'd0, frame_err_cnt}, 32'd1);
    chk("err_early_ready", {31'd0, fft_ready}, 32'd1);
    set_rd(0, 10, mkw(160, 10));
    set_rd(1, 7, mkw(112, 7));
    do_reads(2);

    // fft_last on the first beat of a frame
    send_frame(1, 1, 0);
    tick();
    chk("err_first_cnt", {24'd0, frame_err_cnt}, 32'd2);

    // final bin without fft_last
    send_frame(1, 256, -1);
    tick();
    chk("err_nolast_cnt", {24'd0, frame_err_cnt}, 32'd3);
    chk("err_nolast_ready", {31'd0, fft_ready}, 32'd1);

    // frame B completes but waits on vsync for 1000 cycles
    send_frame(1, 256, 255);
    for (int c = 0; c < 1000; c++) begin
      if (c % 250 == 0) chk("hold_ready", {31'd0, fft_ready}, 32'd0);
      tick();
    end
    set_rd(0, 10, mkw(160, 10));
    do_reads(1);
    chk("hold_ready_end", {31'd0, fft_ready}, 32'd0);
    pulse_vs();
    chk("b_swap_ready", {31'd0, fft_ready}, 32'd1);
    set_rd(0, 10, mkw(320, 20));
    set_rd(1, 7, mkw(130, 8));
    set_rd(2, 255, mkw(8160, 510));
    set_rd(3, 5, mkw(160, 10));
    do_reads(4);

    // reset in the middle of a capture
    send_frame(2, 50, -1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_errcnt", {24'd0, frame_err_cnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, fft_ready}, 32'd1);
    set_rd(0, 10, 32'd0);
    set_rd(1, 0, 32'd0);
    do_reads(2);
    send_frame(2, 256, 255);
    pulse_vs();
    set_rd(0, 10, mkw(240, 15));
    set_rd(1, 255, mkw(6120, 382));
    set_rd(2, 1, mkw(24, 1));
    do_reads(3);
    chk("c_errcnt", {24'd0, frame_err_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
